// File: rtl/imem_fetch_port.sv
// Synchronous-read instruction memory behind a valid/ready fetch port with wait states and a
// byte-enabled load port. Define IMEM_PARITY_EN to store and check one even-parity bit per word.
module imem_fetch_port #(
  parameter int unsigned       INS_ADDRESS = 9,
  parameter int unsigned       INS_W       = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       WAIT_STATES = 0,
  parameter logic [INS_W-1:0]  NOP_WORD    = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic [ADDR_W-1:0]        fetch_addr,
  input  logic                     flush,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [INS_W-1:0]         resp_data,
  output logic                     resp_err,
  input  logic                     ld_we,
  input  logic [INS_ADDRESS-3:0]   ld_addr,
  input  logic [INS_W-1:0]         ld_data,
  input  logic [INS_W/8-1:0]       ld_be
);
  localparam int unsigned DEPTH     = 2**(INS_ADDRESS-2);
  localparam int unsigned NB        = INS_W/8;
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_r;
  logic [2:0]             wait_cnt_r;
  logic                   resp_valid_r;
  logic [INS_W-1:0]       resp_data_r;
  logic                   resp_err_r;
  logic [INS_W-1:0]       mem_r [DEPTH];

  logic                   accept_s;
  logic                   misalign_s;
  logic                   range_err_s;
  logic                   rd_err_s;
  logic                   any_err_s;
  logic [INS_ADDRESS-3:0] rd_idx_s;
  logic [INS_W-1:0]       rd_word_s;

  assign accept_s    = fetch_valid & fetch_ready;
  assign misalign_s  = (fetch_addr[1:0] != 2'b00);
  assign range_err_s = (fetch_addr[ADDR_W-1:INS_ADDRESS] != {(ADDR_W-INS_ADDRESS){1'b0}});
  assign rd_idx_s    = fetch_addr[INS_ADDRESS-1:2];
  assign rd_word_s   = mem_r[rd_idx_s];
  assign any_err_s   = misalign_s | range_err_s | rd_err_s;

  assign resp_valid  = resp_valid_r;
  assign resp_data   = resp_data_r;
  assign resp_err    = resp_err_r;

  // Request acceptance: idle, or draining a response this cycle; never during a flush.
  always_comb begin
    fetch_ready = 1'b0;
    if (flush) begin
      fetch_ready = 1'b0;
    end else if (state_r == IDLE) begin
      fetch_ready = 1'b1;
    end else if (state_r == RESP) begin
      fetch_ready = resp_ready;
    end else begin
      fetch_ready = 1'b0;
    end
  end

  // Load-port byte writes; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      for (int b = 0; b < NB; b++) begin
        if (ld_be[b]) begin
          mem_r[ld_addr][b*8 +: 8] <= ld_data[b*8 +: 8];
        end
      end
    end
  end

`ifdef IMEM_PARITY_EN
  logic             par_r [DEPTH];
  logic [INS_W-1:0] ld_merged_s;

  function automatic logic even_parity(input logic [INS_W-1:0] w);
    return ^w;
  endfunction

  // Word as it will look after the byte-enabled write, so parity covers kept bytes too.
  always_comb begin
    ld_merged_s = mem_r[ld_addr];
    for (int b = 0; b < NB; b++) begin
      if (ld_be[b]) begin
        ld_merged_s[b*8 +: 8] = ld_data[b*8 +: 8];
      end else begin
        ld_merged_s[b*8 +: 8] = mem_r[ld_addr][b*8 +: 8];
      end
    end
  end

  // Parity storage, refreshed on every load-port write.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      par_r[ld_addr] <= even_parity(ld_merged_s);
    end
  end

  assign rd_err_s = (even_parity(rd_word_s) != par_r[rd_idx_s]);
`else
  assign rd_err_s = 1'b0;
`endif

  // Fetch FSM; the array is read once at acceptance and held in the response register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      wait_cnt_r   <= 3'd0;
      resp_valid_r <= 1'b0;
      resp_data_r  <= NOP_WORD;
      resp_err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        resp_err_r  <= any_err_s;
        resp_data_r <= any_err_s ? NOP_WORD : rd_word_s;
      end
      if (flush) begin
        state_r      <= IDLE;
        wait_cnt_r   <= 3'd0;
        resp_valid_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (accept_s) begin
              state_r      <= (WAIT_STATES == 0) ? RESP : WAIT;
              wait_cnt_r   <= WAIT_LOAD;
              resp_valid_r <= (WAIT_STATES == 0);
            end
          end
          WAIT: begin
            if (wait_cnt_r == 3'd0) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
            end else begin
              wait_cnt_r <= wait_cnt_r - 3'd1;
            end
          end
          RESP: begin
            if (resp_ready) begin
              if (accept_s) begin
                state_r      <= (WAIT_STATES == 0) ? RESP : WAIT;
                wait_cnt_r   <= WAIT_LOAD;
                resp_valid_r <= (WAIT_STATES == 0);
              end else begin
                state_r      <= IDLE;
                resp_valid_r <= 1'b0;
              end
            end
          end
          default: begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
